mmio_fabric: RTL and testbench
==============================

Name: mmio_fabric

Overview:
- Parametrised memory-mapped interconnect between the MIPS data port and NSLV peripheral slaves (dmem, accelerators, GPIO banks).
- Replaces the fixed combinational address decode and read mux with a registered, handshaked fabric.
- Adds a per-access wait-state handshake, a timeout, unmapped-address error responses and a saturating error counter.

Parameters:
NSLV, 4, number of slave ports (1..16)
DW, 32, data width
AW, 32, address width
SEL_LSB, 8, slave i occupies the window [i<<SEL_LSB, ((i+1)<<SEL_LSB)-1]
TIMEOUT, 15, ACCESS cycles without s_ready before the fabric aborts with an error (1..255)

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  asynchronous, active-low reset
m_req  in  1  master request; held with address and data stable until m_ready
m_we  in  1  1 = write, 0 = read
m_addr  in  AW  byte address
m_wdata  in  DW  write data
m_rdata  out  DW  registered read data; valid while m_ready=1
m_ready  out  1  one-cycle completion pulse
m_err  out  1  valid with m_ready; 1 = unmapped address or timeout
s_sel  out  NSLV  one-hot slave select; held through ACCESS
s_we  out  1  write strobe; valid while any s_sel bit is set
s_addr  out  AW  m_addr captured at accept
s_wdata  out  DW  m_wdata captured at accept
s_rdata  in  NSLV*DW  concatenated slave read data; slave i uses [i*DW +: DW]
s_ready  in  NSLV  slave i completion; sampled only while s_sel[i]=1
busy  out  1  high in ACCESS and RESP
err_count  out  8  saturating count of error responses

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - m_rdata, s_addr and s_wdata clear to 0.
  - m_ready, m_err, s_sel, s_we and busy clear to 0.
  - err_count and the timeout counter clear to 0.
  - A reset during an active transaction drops it silently; no response is issued.
- Address decode: idx = m_addr >> SEL_LSB. The address is mapped iff idx < NSLV.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On m_req=1 and mapped: capture addr, wdata, we and idx; set s_sel[idx]; clear the timeout counter; go to ACCESS.
  - On m_req=1 and unmapped: load m_rdata=0 and m_err=1; go to RESP. No s_sel bit is asserted.
- ACCESS:
  - If s_ready[idx]=1: register s_rdata slice idx into m_rdata (writes load 0); set m_err=0; drop s_sel and s_we; go to RESP.
  - Otherwise, if the counter equals TIMEOUT-1: load m_rdata=0 and m_err=1; drop s_sel; go to RESP.
  - Otherwise increment the counter and stay in ACCESS.
- RESP:
  - m_ready=1 for exactly one cycle, then return to IDLE.
  - m_req is not sampled in RESP. A request still high on the following IDLE cycle is treated as a new transaction, so the master must drop m_req on m_ready.
- Latency:
  - A slave that is ready in its first ACCESS cycle gives m_ready 2 cycles after m_req is sampled.
  - Each wait cycle adds 1.
  - An unmapped access completes in 1 cycle.
  - A timeout completes in TIMEOUT+1 cycles.
- m_req deasserting mid-transaction has no effect; the transaction runs to completion.
- s_ready bits of unselected slaves are ignored. If several bits are high, only idx counts.
- err_count increments on each error response and holds at 255.
- Captured s_addr and s_wdata hold their values in IDLE and update only on accept.
- m_rdata holds its value until the next RESP load.

Test Plan:
- Zero-wait read: NSLV=4, read 0x0000_0104 with slave1 s_ready=1 and data 0xCAFE_0001. Required: s_sel=0010 for 1 cycle; m_ready 2 cycles after m_req with m_rdata=0xCAFE_0001 and m_err=0.
- Wait-state write: write 0xA5A5_A5A5 to 0x0000_0008 with slave0 s_ready delayed 3 cycles. Required: s_sel=0001 and s_we=1 held for 4 cycles; s_wdata=0xA5A5_A5A5; m_ready at cycle 5; m_err=0.
- Unmapped access: read 0x0000_0400 (idx 4). Required: s_sel stays 0; m_ready next cycle with m_err=1 and m_rdata=0; err_count goes 0→1.
- Timeout: TIMEOUT=15 with slave2 never ready. Required: s_sel=0100 for 15 cycles; m_ready at cycle 16 with m_err=1; err_count increments.
- Saturation and robustness:
  - Issue 260 unmapped accesses. Required: err_count=255.
  - Toggle stray s_ready[3] during a slave1 access. Required: no early completion.
  - Assert rst low mid-ACCESS. Required: all outputs read 0 immediately; no m_ready pulse after release.
- Back-to-back: hold m_req high across two transactions, dropping it one cycle late. Required: exactly one extra transaction starts; every m_ready is a single-cycle pulse.

Source files
------------

// File: rtl/mmio_fabric.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mmio_fabric                                                   |
// | Purpose  : Registered, handshaked memory-mapped interconnect between a   |
// |            single master (MIPS data port) and NSLV peripheral slaves.    |
// |            Address decode selects slave idx = m_addr >> SEL_LSB. Each    |
// |            access waits for the slave's s_ready, aborts after TIMEOUT    |
// |            cycles, and answers unmapped addresses with an error.         |
// |            Error responses are tallied in a saturating 8-bit counter.    |
// | Ports    : clk, rst (async, active-low)                                  |
// |            master : m_req, m_we, m_addr, m_wdata -> m_rdata, m_ready,    |
// |                     m_err                                                |
// |            slaves : s_sel, s_we, s_addr, s_wdata -> s_rdata, s_ready     |
// |            status : busy, err_count                                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mmio_fabric #(
  parameter int NSLV    = 4,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int SEL_LSB = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m_req,
  input  logic               m_we,
  input  logic [AW-1:0]      m_addr,
  input  logic [DW-1:0]      m_wdata,
  output logic [DW-1:0]      m_rdata,
  output logic               m_ready,
  output logic               m_err,
  output logic [NSLV-1:0]    s_sel,
  output logic               s_we,
  output logic [AW-1:0]      s_addr,
  output logic [DW-1:0]      s_wdata,
  input  logic [NSLV*DW-1:0] s_rdata,
  input  logic [NSLV-1:0]    s_ready,
  output logic               busy,
  output logic [7:0]         err_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);

  state_t r_state, w_state_nxt;

  logic [DW-1:0]   r_m_rdata,   w_m_rdata_nxt;
  logic            r_m_ready,   w_m_ready_nxt;
  logic            r_m_err,     w_m_err_nxt;
  logic [NSLV-1:0] r_s_sel,     w_s_sel_nxt;
  logic            r_s_we,      w_s_we_nxt;
  logic [AW-1:0]   r_s_addr,    w_s_addr_nxt;
  logic [DW-1:0]   r_s_wdata,   w_s_wdata_nxt;
  logic            r_busy,      w_busy_nxt;
  logic [7:0]      r_err_count, w_err_count_nxt;
  logic [7:0]      r_cnt,       w_cnt_nxt;

  logic [AW-1:0]   w_idx;
  logic [NSLV-1:0] w_dec;
  logic            w_mapped;
  logic            w_slv_ready;
  logic [DW-1:0]   w_slv_rdata;
  logic            w_err_inc;

  // Decode and return-path selection. The captured one-hot s_sel stands in
  // for the slave index, so ready/data selection needs no binary index and
  // stray ready bits from unselected slaves are masked out naturally.
  always_comb begin
    w_idx       = m_addr >> SEL_LSB;
    w_dec       = '0;
    w_slv_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      w_dec[i] = (w_idx == AW'(i));
      if (r_s_sel[i]) begin
        w_slv_rdata = s_rdata[i*DW +: DW];
      end
    end
    w_mapped    = |w_dec;
    w_slv_ready = |(r_s_sel & s_ready);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_m_rdata_nxt = r_m_rdata;
    w_m_ready_nxt = 1'b0;
    w_m_err_nxt   = r_m_err;
    w_s_sel_nxt   = r_s_sel;
    w_s_we_nxt    = r_s_we;
    w_s_addr_nxt  = r_s_addr;
    w_s_wdata_nxt = r_s_wdata;
    w_cnt_nxt     = r_cnt;
    w_err_inc     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (m_req) begin
          if (w_mapped) begin
            w_s_addr_nxt  = m_addr;
            w_s_wdata_nxt = m_wdata;
            w_s_we_nxt    = m_we;
            w_s_sel_nxt   = w_dec;
            w_cnt_nxt     = 8'd0;
            w_state_nxt   = S_ACCESS;
          end else begin
            w_m_rdata_nxt = '0;
            w_m_err_nxt   = 1'b1;
            w_m_ready_nxt = 1'b1;
            w_err_inc     = 1'b1;
            w_state_nxt   = S_RESP;
          end
        end
      end

      S_ACCESS: begin
        if (w_slv_ready) begin
          // Writes return zero so a stale slave bus never leaks to m_rdata.
          w_m_rdata_nxt = r_s_we ? '0 : w_slv_rdata;
          w_m_err_nxt   = 1'b0;
          w_s_sel_nxt   = '0;
          w_s_we_nxt    = 1'b0;
          w_m_ready_nxt = 1'b1;
          w_state_nxt   = S_RESP;
        end else if (r_cnt == C_TO_LAST) begin
          w_m_rdata_nxt = '0;
          w_m_err_nxt   = 1'b1;
          w_s_sel_nxt   = '0;
          w_s_we_nxt    = 1'b0;
          w_m_ready_nxt = 1'b1;
          w_err_inc     = 1'b1;
          w_state_nxt   = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      S_RESP: begin
        // m_req is deliberately ignored here; the response is one cycle.
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_err_count_nxt = (w_err_inc && (r_err_count != 8'hFF)) ? r_err_count + 8'd1
                                                            : r_err_count;
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_rdata   <= '0;
      r_m_ready   <= 1'b0;
      r_m_err     <= 1'b0;
      r_s_sel     <= '0;
      r_s_we      <= 1'b0;
      r_s_addr    <= '0;
      r_s_wdata   <= '0;
      r_busy      <= 1'b0;
      r_err_count <= 8'd0;
      r_cnt       <= 8'd0;
    end else begin
      r_m_rdata   <= w_m_rdata_nxt;
      r_m_ready   <= w_m_ready_nxt;
      r_m_err     <= w_m_err_nxt;
      r_s_sel     <= w_s_sel_nxt;
      r_s_we      <= w_s_we_nxt;
      r_s_addr    <= w_s_addr_nxt;
      r_s_wdata   <= w_s_wdata_nxt;
      r_busy      <= w_busy_nxt;
      r_err_count <= w_err_count_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign m_rdata   = r_m_rdata;
  assign m_ready   = r_m_ready;
  assign m_err     = r_m_err;
  assign s_sel     = r_s_sel;
  assign s_we      = r_s_we;
  assign s_addr    = r_s_addr;
  assign s_wdata   = r_s_wdata;
  assign busy      = r_busy;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_mmio_fabric.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mmio_fabric                                                |
// | Purpose  : Self-checking bench for mmio_fabric (NSLV=4, DW=AW=32,        |
// |            SEL_LSB=8, TIMEOUT=15). Directed vector table, randomized     |
// |            transactions against a behavioural model, and hand-written    |
// |            reset / back-to-back / saturation sequences.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mmio_fabric;

  localparam int NSLV    = 4;
  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int SEL_LSB = 8;
  localparam int TIMEOUT = 15;
  localparam int NEVER   = 1000;

  logic               clk = 1'b0;
  logic               rst;
  logic               m_req;
  logic               m_we;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_wdata;
  logic [DW-1:0]      m_rdata;
  logic               m_ready;
  logic               m_err;
  logic [NSLV-1:0]    s_sel;
  logic               s_we;
  logic [AW-1:0]      s_addr;
  logic [DW-1:0]      s_wdata;
  logic [NSLV*DW-1:0] s_rdata;
  logic [NSLV-1:0]    s_ready;
  logic               busy;
  logic [7:0]         err_count;

  mmio_fabric #(
    .NSLV(NSLV), .DW(DW), .AW(AW), .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          model_err = 0;
  logic [31:0] sdata [NSLV];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    bit          stray;
    int          lat;
    bit          err;
    logic [31:0] rd;
    int          selcyc;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One master transaction with a behavioural slave that raises ready after
  // 'waits' access cycles; 'stray' toggles ready on all other slaves.
  task automatic do_txn(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits, input bit stray,
                        input int e_lat, input bit e_err, input logic [31:0] e_rd,
                        input int e_selcyc);
    int          cyc, selcyc, lat;
    bit          done, badsel, badbusy;
    logic [NSLV-1:0] esel;
    logic [31:0] idx, got_rd;
    logic        got_err;
    idx  = addr >> SEL_LSB;
    esel = (idx < NSLV) ? NSLV'(1 << idx) : '0;
    for (int i = 0; i < NSLV; i++) s_rdata[i*DW +: DW] = sdata[i];
    m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; s_ready = '0;
    done = 0; cyc = 0; selcyc = 0; badsel = 0; badbusy = 0; lat = -1;
    got_rd = '0; got_err = 1'b0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
      m_req = 1'b0;
      if (busy !== 1'b1) badbusy = 1;
      if (s_sel != '0) begin
        selcyc++;
        if (s_sel !== esel || s_we !== we || s_addr !== addr || s_wdata !== wdata) badsel = 1;
      end
      if (m_ready === 1'b1) begin
        done = 1; lat = cyc; got_rd = m_rdata; got_err = m_err;
      end else begin
        s_ready = (stray && (cyc % 2 == 1)) ? ~esel : '0;
        if (s_sel != '0 && selcyc > waits) s_ready = s_ready | esel;
      end
    end
    s_ready = '0;
    if (e_err && model_err < 255) model_err++;
    chk({tag, "_lat"},    64'(lat),     64'(e_lat));
    chk({tag, "_rdata"},  64'(got_rd),  64'(e_rd));
    chk({tag, "_err"},    64'(got_err), 64'(e_err));
    chk({tag, "_selcyc"}, 64'(selcyc),  64'(e_selcyc));
    chk({tag, "_selbus"}, 64'(badsel),  64'(0));
    chk({tag, "_busy"},   64'(badbusy), 64'(0));
    tick();
    chk({tag, "_pulse"},  64'(m_ready),   64'(0));
    chk({tag, "_idle"},   64'(busy),      64'(0));
    chk({tag, "_hold"},   64'(m_rdata),   64'(e_rd));
    chk({tag, "_errcnt"}, 64'(err_count), 64'(model_err));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"},  64'(m_rdata),   64'(0));
    chk({tag, "_ready"},  64'(m_ready),   64'(0));
    chk({tag, "_err"},    64'(m_err),     64'(0));
    chk({tag, "_sel"},    64'(s_sel),     64'(0));
    chk({tag, "_we"},     64'(s_we),      64'(0));
    chk({tag, "_saddr"},  64'(s_addr),    64'(0));
    chk({tag, "_swdata"}, 64'(s_wdata),   64'(0));
    chk({tag, "_busy"},   64'(busy),      64'(0));
    chk({tag, "_errcnt"}, 64'(err_count), 64'(0));
  endtask

  initial begin
    int          pulses, first, second;
    bit          we;
    logic [31:0] addr, wd, idx, rd;
    int          waits, lat, selcyc;
    bit          mapped, err, stray;

    rst = 1'b0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    s_rdata = '0; s_ready = '0;
    for (int i = 0; i < NSLV; i++) sdata[i] = 32'hCAFE_0000 | 32'(i);

    // Reset state
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();

    // Directed vectors: {we, addr, wdata, waits, stray} -> {lat, err, rdata, selcyc}
    tbl[0] = '{1'b0, 32'h0000_0104, 32'h0,         0,     1'b0, 2,  1'b0, 32'hCAFE_0001, 1};
    tbl[1] = '{1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 3,     1'b0, 5,  1'b0, 32'h0,         4};
    tbl[2] = '{1'b0, 32'h0000_0400, 32'h0,         0,     1'b0, 1,  1'b1, 32'h0,         0};
    tbl[3] = '{1'b0, 32'h0000_02FC, 32'h0,         NEVER, 1'b0, 16, 1'b1, 32'h0,         15};
    tbl[4] = '{1'b0, 32'h0000_0304, 32'h0,         14,    1'b0, 16, 1'b0, 32'hCAFE_0003, 15};
    tbl[5] = '{1'b0, 32'h0000_0100, 32'h0,         2,     1'b1, 4,  1'b0, 32'hCAFE_0001, 3};
    tbl[6] = '{1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 0,     1'b0, 1,  1'b1, 32'h0,         0};
    for (int i = 0; i < 7; i++) begin
      do_txn($sformatf("v%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].waits,
             tbl[i].stray, tbl[i].lat, tbl[i].err, tbl[i].rd, tbl[i].selcyc);
    end

    // Randomized transactions against the behavioural model
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NSLV; i++) sdata[i] = $urandom;
      we    = 1'($urandom);
      wd    = $urandom;
      if ($urandom_range(0, 7) == 0) addr = $urandom;
      else addr = (32'($urandom_range(0, 5)) << SEL_LSB) | 32'($urandom_range(0, 255));
      waits = $urandom_range(0, 20);
      stray = 1'($urandom);
      idx    = addr >> SEL_LSB;
      mapped = (idx < NSLV);
      err    = !mapped || (waits >= TIMEOUT);
      lat    = !mapped ? 1 : ((waits < TIMEOUT) ? waits + 2 : TIMEOUT + 1);
      selcyc = !mapped ? 0 : ((waits < TIMEOUT) ? waits + 1 : TIMEOUT);
      rd     = (err || we) ? 32'h0 : sdata[idx[1:0]];
      do_txn($sformatf("r%0d", n), we, addr, wd, waits, stray, lat, err, rd, selcyc);
    end

    // Back-to-back: m_req held through the first response and one IDLE cycle
    s_ready = 4'b0001;
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0010;
    pulses = 0; first = -1; second = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 4) m_req = 1'b0;
      if (m_ready === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    s_ready = '0;
    chk("b2b_pulses", 64'(pulses), 64'(2));
    chk("b2b_first",  64'(first),  64'(2));
    chk("b2b_second", 64'(second), 64'(5));

    // Reset asserted mid-ACCESS
    m_req = 1'b1; m_we = 1'b1; m_addr = 32'h0000_0200; m_wdata = 32'h1234_5678;
    tick();
    m_req = 1'b0;
    tick(); tick();
    chk("rstmid_sel_before", 64'(s_sel), 64'(4'b0100));
    #1 rst = 1'b0;
    #1 chk_all_zero("rstmid");
    model_err = 0;
    tick();
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m_ready === 1'b1 || busy === 1'b1) pulses++;
    end
    chk("rstmid_no_resp", 64'(pulses), 64'(0));

    // Saturation: 260 unmapped accesses
    for (int n = 0; n < 260; n++) begin
      do_txn($sformatf("sat%0d", n), 1'b0, 32'h0000_0400 + 32'(n), 32'h0, 0, 1'b0,
             1, 1'b1, 32'h0, 0);
    end
    chk("sat_final", 64'(err_count), 64'(255));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
